inst_fetch: RTL and testbench

Instruction-fetch initiator for the combinational instruction ROM. It holds the fetch PC and drives the ROM address every cycle. It checks the ROM's `accessable` flag and alignment, then buffers fetched words with their PCs in a small prefetch queue. The CPU front end drains that queue through a valid/ready handshake. Branch and jump redirects flush the queue and restart fetch. An inaccessible or misaligned fetch parks the block in a fault state until the next redirect.

---
 rtl/inst_fetch.sv | 112 +++++++++++
 tb/tb_inst_fetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: drives the ROM from a fetch PC, buffers fetched words with
// their PCs in a circular prefetch queue, and parks in a fault state on a bad fetch address.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        rom_accessable,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        fault,
   output logic [31:0] fault_pc
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   localparam logic StFetch = 1'b0;
   localparam logic StFault = 1'b1;

   logic          state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   fault_pc_q, fault_pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;

   logic [31:0]   mem_pc   [DEPTH];
   logic [31:0]   mem_data [DEPTH];

   logic bad, pop, push;

   assign rom_addr   = fetch_pc_q;
   assign inst_valid = (count_q != '0);
   assign inst       = inst_valid ? mem_data[rd_ptr_q] : '0;
   assign inst_pc    = inst_valid ? mem_pc[rd_ptr_q] : '0;
   assign fault      = (state_q == StFault);
   assign fault_pc   = fault_pc_q;

   assign bad  = !rom_accessable || (fetch_pc_q[1:0] != 2'b00);
   assign pop  = inst_valid && inst_ready;
   // A pop in the same cycle frees a slot, so a full queue can still accept a word.
   assign push = (state_q == StFetch) && !bad && ((count_q < FULL) || pop) && !redirect;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      fault_pc_d = fault_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect) begin
         // Any same-cycle pop has been taken by the consumer; everything else is dropped.
         state_d    = StFetch;
         fetch_pc_d = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
         end else if (!push && pop) begin
            count_d = count_q - (AW + 1)'(1);
         end
         if ((state_q == StFetch) && bad) begin
            state_d    = StFault;
            fault_pc_d = fetch_pc_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StFetch;
         fetch_pc_q <= RESET_PC;
         fault_pc_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         fault_pc_q <= fault_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Queue storage needs no reset: outputs are masked by count while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr_q]   <= fetch_pc_q;
         mem_data[wr_ptr_q] <= rom_data;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a cycle table for boot/fault/recovery and a
// scoreboard of expected PCs for the streaming and redirect corner cases.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        rom_accessable;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        fault;
   logic [31:0] fault_pc;

   logic [31:0] rom_limit = 32'h0000_000C;
   int          errors = 0;
   int          checks = 0;
   logic        sb_on = 1'b0;
   logic [31:0] exp_q[$];

   inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .rom_accessable (rom_accessable),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .fault          (fault),
      .fault_pc       (fault_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'h0: rom_word = 32'h3c11_4000;
         32'h4: rom_word = 32'h2631_0000;
         32'h8: rom_word = 32'h0220_0008;
         default: rom_word = a ^ 32'h5a5a_0000;
      endcase
   endfunction

   assign rom_data       = rom_word(rom_addr);
   assign rom_accessable = (rom_addr < rom_limit) ||
                           ((rom_addr >= 32'h0040_0000) && (rom_addr < 32'h0040_0100));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a falling edge: drive inputs, observe any handshake, advance one cycle.
   task automatic cyc(input logic rdy, input logic rd, input logic [31:0] rpc);
      logic [31:0] e;
      inst_ready  = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      #1;
      if (sb_on && inst_valid && inst_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_pc", inst_pc, 32'hxxxx_xxxx);
         end else begin
            e = exp_q.pop_front();
            chk("sb_pc", inst_pc, e);
            chk("sb_inst", inst, rom_word(e));
         end
      end
      @(negedge clk);
   endtask

   task automatic reset_dut(input logic [31:0] limit);
      @(negedge clk);
      reset       = 1'b1;
      inst_ready  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      rom_limit   = limit;
      sb_on       = 1'b0;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      logic        rdy;
      logic        rd;
      logic [31:0] rpc;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic [31:0] e_addr;
      logic        e_fault;
      logic [31:0] e_fpc;
   } vec_t;

   vec_t tbl[9];

   initial begin
      // Each row: expected outputs at this falling edge, then inputs for the next rising edge.
      tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,       32'h0,
                 32'h0,         1'b0, 32'h0};
      tbl[1] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,       32'h3c11_4000,
                 32'h4,         1'b0, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,       32'h2631_0000,
                 32'h8,         1'b0, 32'h0};
      tbl[3] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8,       32'h0220_0008,
                 32'hC,         1'b0, 32'h0};
      tbl[4] = '{1'b1, 1'b1, 32'h0040_0000, 1'b0, 32'h0,       32'h0,
                 32'hC,         1'b1, 32'hC};
      tbl[5] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,       32'h0,
                 32'h0040_0000, 1'b0, 32'hC};
      tbl[6] = '{1'b1, 1'b1, 32'h0040_0002, 1'b1, 32'h0040_0000, 32'h5a1a_0000,
                 32'h0040_0004, 1'b0, 32'hC};
      tbl[7] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,       32'h0,
                 32'h0040_0002, 1'b0, 32'hC};
      tbl[8] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,       32'h0,
                 32'h0040_0002, 1'b1, 32'h0040_0002};

      // Boot stream, fault at 0xC, recovery, misaligned redirect.
      reset_dut(32'h0000_000C);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("row%0d_valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
         chk($sformatf("row%0d_inst_pc", i), inst_pc, tbl[i].e_pc);
         chk($sformatf("row%0d_inst", i), inst, tbl[i].e_inst);
         chk($sformatf("row%0d_rom_addr", i), rom_addr, tbl[i].e_addr);
         chk($sformatf("row%0d_fault", i), 32'(fault), 32'(tbl[i].e_fault));
         chk($sformatf("row%0d_fault_pc", i), fault_pc, tbl[i].e_fpc);
         cyc(tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
      end

      // Backpressure: queue fills to 4, fetch PC parks at 0x10, then streams without gaps.
      reset_dut(32'h0000_1000);
      for (int i = 0; i < 10; i++) begin
         if (i >= 4) chk("bp_rom_addr_hold", rom_addr, 32'h10);
         cyc(1'b0, 1'b0, 32'h0);
      end
      chk("bp_head_pc", inst_pc, 32'h0);
      for (int i = 0; i < 12; i++) exp_q.push_back(32'(i * 4));
      sb_on = 1'b1;
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
         chk("bp_stream_valid", 32'(inst_valid), 32'h1);
         cyc(1'b1, 1'b0, 32'h0);
      end
      chk("bp_stream_remaining", 32'(exp_q.size()), 32'h0);
      sb_on = 1'b0;

      // Redirect with a simultaneous pop: head taken once, two entries dropped.
      reset_dut(32'h0000_1000);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0);
      chk("rp_rom_addr", rom_addr, 32'hC);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0040_0020);
      exp_q.push_back(32'h0040_0024);
      sb_on = 1'b1;
      cyc(1'b1, 1'b1, 32'h0040_0020);
      chk("rp_rom_addr_after", rom_addr, 32'h0040_0020);
      chk("rp_valid_gap", 32'(inst_valid), 32'h0);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(1'b1, 1'b0, 32'h0);
      chk("rp_remaining", 32'(exp_q.size()), 32'h0);
      sb_on = 1'b0;

      // Asynchronous reset while the queue is full.
      reset_dut(32'h0000_1000);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0);
      chk("ar_valid_before", 32'(inst_valid), 32'h1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("ar_valid", 32'(inst_valid), 32'h0);
      chk("ar_rom_addr", rom_addr, 32'h0);
      chk("ar_inst_pc", inst_pc, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
